port_monitor: RTL and testbench

Receive-side checker for the divided-clock counter port: samples an externally generated slow strobe and its 7-bit counter bus in the fast `clk` domain, confirms the bus advances by exactly +1 (mod 128) per strobe period, and measures the strobe period in `clk` cycles. It sits on the bring-up board opposite the clock-divider test pattern generator and drives status LEDs or a debug register bank.

---
 rtl/port_monitor_pkg.sv | 22 ++
 rtl/port_monitor_bit_sync.sv | 34 +++
 rtl/port_monitor.sv | 181 ++++++++++++++++++
 tb/tb_port_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_monitor_pkg.sv
// port_monitor_pkg
// Shared definitions for the divided-clock counter port checker:
// default widths and the tracking state enumeration.
// No ports (package).

package port_monitor_pkg;

    localparam int DEF_DATA_W     = 7;
    localparam int DEF_PERIOD_W   = 24;
    localparam int DEF_ERR_W      = 16;
    localparam int DEF_LOCK_COUNT = 4;

    // IDLE   : no reference sample yet (after reset or after a timeout)
    // TRACK  : have a reference, counting consecutive good increments
    // LOCKED : stream verified, mismatches are counted as errors
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/port_monitor_bit_sync.sv
// bit_sync
// Parameterized-width two-flop synchronizer for signals arriving
// asynchronously to clk. Each bit is synchronized independently; the
// caller must guarantee the bus is stable around the sampling point.
// Ports:
//   clk        in   destination clock
//   rst        in   asynchronous active-low reset (flops clear to 0)
//   async_bits in   WIDTH  bits from the foreign domain
//   sync_bits  out  WIDTH  synchronized copy, two clk cycles of latency

module bit_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_bits,
    output logic [WIDTH-1:0] sync_bits
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make meta and sync_bits two distinct
    // stages; blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta      <= '0;
            sync_bits <= '0;
        end else begin
            meta      <= async_bits;
            sync_bits <= meta;
        end
    end

endmodule

// File: rtl/port_monitor.sv
// port_monitor
// Receive-side checker for the divided-clock counter port. Synchronizes
// the slow strobe and its counter bus into clk, captures the bus on each
// strobe falling edge, verifies it advances by +1 (mod 2**DATA_W) per
// strobe period, measures the strobe period in clk cycles and counts
// mismatches seen while locked.
// Ports:
//   clk           in   fast system clock
//   rst           in   asynchronous active-low reset
//   port_in       in   DATA_W    counter bus from pattern generator (async)
//   strobe_in     in   1         slow strobe from pattern generator (async)
//   sample_valid  out  1         one-cycle pulse per capture event
//   sample        out  DATA_W    last captured bus value
//   period        out  PERIOD_W  clk cycles between the last two captures
//   locked        out  1         high while in LOCKED
//   error_count   out  ERR_W     saturating count of mismatches while LOCKED

module port_monitor
    import port_monitor_pkg::*;
#(
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          PERIOD_W   = DEF_PERIOD_W,
    parameter int          ERR_W      = DEF_ERR_W,
    parameter int          LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int unsigned TIMEOUT    = 2**PERIOD_W - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   port_in,
    input  logic                strobe_in,
    output logic                sample_valid,
    output logic [DATA_W-1:0]   sample,
    output logic [PERIOD_W-1:0] period,
    output logic                locked,
    output logic [ERR_W-1:0]    error_count
);

    localparam int                  GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0]   LOCK_V    = GOOD_W'(LOCK_COUNT);
    localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);

    // ------------------------------------------------------------------
    // Synchronization and capture detection
    // ------------------------------------------------------------------
    logic [DATA_W:0]   sync_bits;
    logic              strobe_s;
    logic              strobe_d;
    logic [DATA_W-1:0] bus_s;
    logic              capture;

    bit_sync #(
        .WIDTH(DATA_W + 1)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_bits ({strobe_in, port_in}),
        .sync_bits  (sync_bits)
    );

    assign strobe_s = sync_bits[DATA_W];
    assign bus_s    = sync_bits[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_d <= 1'b0;
        end else begin
            strobe_d <= strobe_s;
        end
    end

    // The generator moves the bus on its rising edge, so by the falling
    // edge the synchronized bus has been stable for half a strobe period.
    assign capture = strobe_d & ~strobe_s;

    // ------------------------------------------------------------------
    // Period counter: restarts at 1 on the capture cycle so that the
    // value seen at the next capture equals the full cycle distance.
    // ------------------------------------------------------------------
    logic [PERIOD_W-1:0] period_cnt;
    logic                timed_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
        end else if (capture) begin
            period_cnt <= PERIOD_W'(1);
        end else if (period_cnt != TIMEOUT_V) begin
            period_cnt <= period_cnt + PERIOD_W'(1);
        end
    end

    assign timed_out = (period_cnt == TIMEOUT_V);

    // ------------------------------------------------------------------
    // Compare against the previous sample; the +1 wraps naturally at
    // DATA_W bits, so 2**DATA_W-1 -> 0 counts as a good increment.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] next_expected;
    logic              match;

    assign next_expected = sample + DATA_W'(1);
    assign match         = (bus_s == next_expected);

    // ------------------------------------------------------------------
    // Tracking FSM with registered outputs. A capture in the same cycle
    // as a timeout takes priority, so the timeout branches sit under the
    // no-capture path.
    // ------------------------------------------------------------------
    state_t            state;
    logic [GOOD_W-1:0] good;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            good         <= '0;
            sample_valid <= 1'b0;
            sample       <= '0;
            period       <= '0;
            locked       <= 1'b0;
            error_count  <= '0;
        end else begin
            sample_valid <= capture;

            case (state)
                IDLE: begin
                    // First capture only establishes a reference; there is
                    // no previous edge to measure a period against.
                    if (capture) begin
                        sample <= bus_s;
                        good   <= '0;
                        state  <= TRACK;
                        locked <= 1'b0;
                    end
                end

                TRACK: begin
                    if (capture) begin
                        sample <= bus_s;
                        period <= period_cnt;
                        if (match) begin
                            good <= good + GOOD_W'(1);
                            if (good + GOOD_W'(1) == LOCK_V) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end else if (timed_out) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                end

                LOCKED: begin
                    if (capture) begin
                        sample <= bus_s;
                        period <= period_cnt;
                        if (!match) begin
                            if (error_count != '1) begin
                                error_count <= error_count + ERR_W'(1);
                            end
                            good   <= '0;
                            state  <= TRACK;
                            locked <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_monitor.sv
// tb_port_monitor
// Scoreboard bench for port_monitor. The stimulus process drives strobe
// and bus patterns and, for each strobe falling edge it issues, pushes
// the response predicted by a reference model of the checking rules.
// A monitor process pops and compares whenever sample_valid is seen.

module tb_port_monitor;

    localparam int DATA_W     = 7;
    localparam int PERIOD_W   = 24;
    localparam int ERR_W      = 2;
    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 100;
    localparam int MOD        = 1 << DATA_W;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [DATA_W-1:0]   port_in = '0;
    logic                strobe_in = 1'b0;
    logic                sample_valid;
    logic [DATA_W-1:0]   sample;
    logic [PERIOD_W-1:0] period;
    logic                locked;
    logic [ERR_W-1:0]    error_count;

    port_monitor #(
        .DATA_W     (DATA_W),
        .PERIOD_W   (PERIOD_W),
        .ERR_W      (ERR_W),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_in      (port_in),
        .strobe_in    (strobe_in),
        .sample_valid (sample_valid),
        .sample       (sample),
        .period       (period),
        .locked       (locked),
        .error_count  (error_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: rules stated as "has a reference value", "is the
    // stream verified", run length of good steps, and gap arithmetic on
    // capture times.
    // ------------------------------------------------------------------
    typedef struct {
        int smp;
        int per;
        int lck;
        int err;
    } exp_t;

    exp_t sb[$];

    bit m_ref;
    bit m_locked;
    int m_good;
    int m_errs;
    int m_last_val;
    int m_last_cyc;
    int m_period;

    task automatic model_reset();
        m_ref      = 1'b0;
        m_locked   = 1'b0;
        m_good     = 0;
        m_errs     = 0;
        m_last_val = 0;
        m_last_cyc = 0;
        m_period   = 0;
    endtask

    task automatic model_capture(input int v, input int c);
        // A silence longer than TIMEOUT cycles discards the reference;
        // a gap of exactly TIMEOUT still counts as a normal capture.
        if (m_ref && (c - m_last_cyc) > TIMEOUT) begin
            m_ref    = 1'b0;
            m_locked = 1'b0;
        end
        if (!m_ref) begin
            m_ref  = 1'b1;
            m_good = 0;
        end else begin
            m_period = c - m_last_cyc;
            if (v == (m_last_val + 1) % MOD) begin
                if (!m_locked) begin
                    m_good++;
                    if (m_good >= LOCK_COUNT) m_locked = 1'b1;
                end
            end else begin
                if (m_locked) begin
                    m_errs   = (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
                    m_locked = 1'b0;
                end
                m_good = 0;
            end
        end
        m_last_val = v;
        m_last_cyc = c;
        sb.push_back('{v, m_period, int'(m_locked), m_errs});
    endtask

    // One strobe period: bus changes with the rising edge, held high for
    // h cycles, falling edge (capture) recorded, then low for l cycles.
    task automatic send(input int v, input int h, input int l);
        port_in   = DATA_W'(v);
        strobe_in = 1'b1;
        repeat (h) @(negedge clk);
        strobe_in = 1'b0;
        model_capture(v, cyc);
        repeat (l) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst && sample_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_sample_valid: got sample %0d with no pending capture (t=%0t)",
                         sample, $time);
            end else begin
                mon_e = sb.pop_front();
                check("sample",      32'(sample),      32'(mon_e.smp));
                check("period",      32'(period),      32'(mon_e.per));
                check("locked",      32'(locked),      32'(mon_e.lck));
                check("error_count", 32'(error_count), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int v;
    int fall_cyc;
    int drop_cyc;

    initial begin
        model_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample_valid", 32'(sample_valid), 0);
        check("rst_sample",       32'(sample),       0);
        check("rst_period",       32'(period),       0);
        check("rst_locked",       32'(locked),       0);
        check("rst_error_count",  32'(error_count),  0);
        rst = 1'b1;
        @(negedge clk);

        // Period 20, bus 0,1,2,... : lock after the fifth capture.
        for (int i = 0; i < 8; i++) send(i, 10, 10);

        // Continue at the minimum phase width through the 127 -> 0 wrap.
        for (int i = 8; i < 128; i++) send(i, 3, 3);
        for (int i = 0; i < 12; i++) send(i, 3, 3);

        // 10,11 then 13: error, back to tracking; 14..17 relock.
        send(13, 10, 10);
        for (int i = 14; i < 18; i++) send(i, 10, 10);

        // Gap of exactly TIMEOUT: capture wins, still locked, period=TIMEOUT.
        send(18, 90, 10);

        // Stop the strobe: locked must drop TIMEOUT cycles after the
        // capture edge, which lands 3 clk edges after the falling drive.
        send(19, 10, 0);
        fall_cyc = cyc;
        drop_cyc = -1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (!locked && drop_cyc < 0) drop_cyc = cyc;
        end
        check("timeout_drop_delay", 32'(drop_cyc - fall_cyc), 32'(TIMEOUT + 3));

        // Next edge restarts from IDLE: period keeps its old value.
        send(20, 10, 10);

        // Five mismatches interleaved with relocks; error_count saturates.
        v = 21;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                send(v, 4, 4);
                v = (v + 1) % MOD;
            end
            v = (v + 5) % MOD;
            send(v, 4, 4);
            v = (v + 1) % MOD;
        end
        for (int i = 0; i < 4; i++) begin
            send(v, 4, 4);
            v = (v + 1) % MOD;
        end

        // Randomized phases and occasional bus jumps.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) v = int'($urandom_range(0, MOD - 1));
            else                           v = (v + 1) % MOD;
            send(v, int'($urandom_range(3, 12)), int'($urandom_range(3, 12)));
        end

        // Make sure we are locked, then reset in the middle of a period.
        for (int i = 0; i < 6; i++) begin
            v = (v + 1) % MOD;
            send(v, 5, 5);
        end
        v = (v + 1) % MOD;
        port_in   = DATA_W'(v);
        strobe_in = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_sample_valid", 32'(sample_valid), 0);
        check("midrst_sample",       32'(sample),       0);
        check("midrst_period",       32'(period),       0);
        check("midrst_locked",       32'(locked),       0);
        check("midrst_error_count",  32'(error_count),  0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Resume: IDLE capture, then normal tracking and relock.
        for (int i = 0; i < 6; i++) begin
            send(v, 5, 5);
            v = (v + 1) % MOD;
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
